// File: rtl/reg_ref_exec.sv
// Register-reference instruction executor for the Basic Computer datapath.
// Holds AC, drives the external E flip-flop, and executes the IR[11:0] micro-ops one per clock.
module reg_ref_exec #(
  parameter int AC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [11:0]     ir,
  input  logic            ac_load,
  input  logic [AC_W-1:0] ac_in,
  input  logic            e_q,
  output logic            ff_en,
  output logic            e_clr,
  output logic            e_indata,
  output logic [AC_W-1:0] ac_out,
  output logic            busy,
  output logic            done,
  output logic            skip,
  output logic            halt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [11:0] OP_CLA = 12'h800;
  localparam logic [11:0] OP_CLE = 12'h400;
  localparam logic [11:0] OP_CMA = 12'h200;
  localparam logic [11:0] OP_CME = 12'h100;
  localparam logic [11:0] OP_CIR = 12'h080;
  localparam logic [11:0] OP_CIL = 12'h040;
  localparam logic [11:0] OP_INC = 12'h020;
  localparam logic [11:0] OP_SPA = 12'h010;
  localparam logic [11:0] OP_SNA = 12'h008;
  localparam logic [11:0] OP_SZA = 12'h004;
  localparam logic [11:0] OP_SZE = 12'h002;
  localparam logic [11:0] OP_HLT = 12'h001;

  state_t          state, state_nxt;
  logic [11:0]     pending, pending_nxt;
  logic [11:0]     op;
  logic [AC_W-1:0] ac, ac_nxt;
  logic            skip_acc, skip_nxt;
  logic            halt_q, halt_nxt;

  // One-hot of the highest set pending bit; later loop iterations win.
  always_comb begin
    op = '0;
    for (int i = 0; i < 12; i++) begin
      if (pending[i]) op = 12'b1 << i;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    ac_nxt      = ac;
    skip_nxt    = skip_acc;
    halt_nxt    = halt_q;
    ff_en       = 1'b0;
    e_clr       = 1'b0;
    e_indata    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    skip        = 1'b0;

    case (state)
      IDLE: begin
        if (ac_load) ac_nxt = ac_in;
        if (start && !halt_q) begin
          pending_nxt = ir;
          skip_nxt    = 1'b0;
          state_nxt   = (ir != 12'h000) ? EXEC : DONE;
        end
      end

      EXEC: begin
        busy        = 1'b1;
        pending_nxt = pending & ~op;
        if (pending_nxt == 12'h000) state_nxt = DONE;
        case (op)
          OP_CLA: ac_nxt = '0;
          OP_CLE: begin
            ff_en = 1'b1;
            e_clr = 1'b1;
          end
          OP_CMA: ac_nxt = ~ac;
          OP_CME: begin
            ff_en    = 1'b1;
            e_indata = ~e_q;
          end
          OP_CIR: begin
            ac_nxt   = {e_q, ac[AC_W-1:1]};
            ff_en    = 1'b1;
            e_indata = ac[0];
          end
          OP_CIL: begin
            ac_nxt   = {ac[AC_W-2:0], e_q};
            ff_en    = 1'b1;
            e_indata = ac[AC_W-1];
          end
          OP_INC: ac_nxt = ac + AC_W'(1);
          OP_SPA: skip_nxt = skip_acc | ~ac[AC_W-1];
          OP_SNA: skip_nxt = skip_acc | ac[AC_W-1];
          OP_SZA: skip_nxt = skip_acc | (ac == '0);
          OP_SZE: skip_nxt = skip_acc | ~e_q;
          OP_HLT: halt_nxt = 1'b1;
          default: ;
        endcase
      end

      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        skip      = skip_acc;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      ac       <= '0;
      skip_acc <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      ac       <= ac_nxt;
      skip_acc <= skip_nxt;
      halt_q   <= halt_nxt;
    end
  end

  assign ac_out = ac;
  assign halt   = halt_q;

endmodule

// File: tb/tb_reg_ref_exec.sv
// Self-checking bench for reg_ref_exec: an E flip-flop model closes the feedback loop,
// and a reference model queues per-cycle and per-instruction expectations.
module tb_reg_ref_exec;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset, start, ac_load, e_q;
  logic [11:0]   ir;
  logic [W-1:0]  ac_in, ac_out;
  logic          ff_en, e_clr, e_indata, busy, done, skip, halt;

  logic          e_ff = 1'b0;
  logic          e_preset_en = 1'b0;
  logic          e_preset_val = 1'b0;

  typedef struct packed {
    logic         ff_en;
    logic         e_clr;
    logic         e_indata;
    logic [W-1:0] ac_after;
  } cyc_t;

  typedef struct packed {
    logic [W-1:0] ac;
    logic         e;
    logic         skip;
    logic         halt;
    logic [4:0]   n;
  } res_t;

  cyc_t         cyc_q[$];
  res_t         res_q[$];
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] m_ac  = '0;
  logic         m_e   = 1'b0;
  logic         m_halt = 1'b0;

  reg_ref_exec #(.AC_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ir       (ir),
    .ac_load  (ac_load),
    .ac_in    (ac_in),
    .e_q      (e_q),
    .ff_en    (ff_en),
    .e_clr    (e_clr),
    .e_indata (e_indata),
    .ac_out   (ac_out),
    .busy     (busy),
    .done     (done),
    .skip     (skip),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  // External E flip-flop, captured on the same edge as AC.
  always @(posedge clk) begin
    if (e_preset_en)  e_ff <= e_preset_val;
    else if (ff_en)   e_ff <= e_clr ? 1'b0 : e_indata;
  end
  assign e_q = e_ff;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: walks the set bits from 11 down to 0.
  function automatic void model(input logic [11:0] instr);
    cyc_t c;
    logic sk;
    int   n;
    sk = 1'b0;
    n  = 0;
    for (int b = 11; b >= 0; b--) begin
      if (instr[b]) begin
        c = '0;
        n++;
        case (b)
          11: m_ac = '0;
          10: begin c.ff_en = 1'b1; c.e_clr = 1'b1; m_e = 1'b0; end
          9:  m_ac = ~m_ac;
          8:  begin c.ff_en = 1'b1; c.e_indata = ~m_e; m_e = ~m_e; end
          7:  begin
                c.ff_en = 1'b1; c.e_indata = m_ac[0];
                m_ac = {m_e, m_ac[W-1:1]}; m_e = c.e_indata;
              end
          6:  begin
                c.ff_en = 1'b1; c.e_indata = m_ac[W-1];
                m_ac = {m_ac[W-2:0], m_e}; m_e = c.e_indata;
              end
          5:  m_ac = m_ac + 16'd1;
          4:  sk = sk | ~m_ac[W-1];
          3:  sk = sk | m_ac[W-1];
          2:  sk = sk | (m_ac == 16'h0000);
          1:  sk = sk | ~m_e;
          default: m_halt = 1'b1;
        endcase
        c.ac_after = m_ac;
        cyc_q.push_back(c);
      end
    end
    res_q.push_back('{ac: m_ac, e: m_e, skip: sk, halt: m_halt, n: 5'(n)});
  endfunction

  task automatic set_state(input logic [W-1:0] ac_val, input logic e_val);
    @(negedge clk);
    ac_load = 1'b1; ac_in = ac_val;
    e_preset_en = 1'b1; e_preset_val = e_val;
    @(negedge clk);
    ac_load = 1'b0; e_preset_en = 1'b0;
    m_ac = ac_val; m_e = e_val;
  endtask

  task automatic run_instr(input string name, input logic [11:0] instr,
                           input logic do_load, input logic [W-1:0] load_val,
                           input logic noisy);
    cyc_t         c;
    res_t         r;
    logic [W-1:0] exp_ac;
    int           cycles;
    @(negedge clk);
    if (do_load) m_ac = load_val;
    exp_ac = m_ac;
    model(instr);
    start = 1'b1; ir = instr; ac_load = do_load; ac_in = load_val;
    @(negedge clk);
    start = 1'b0; ac_load = 1'b0; ir = 12'($urandom); ac_in = 16'($urandom);
    cycles = 0;
    while (!done && cycles < 40) begin
      total++;
      if (busy !== 1'b1 || cyc_q.size() == 0) begin
        bad++;
        $display("FAIL %s exec%0d: busy=%b queued=%0d, want busy=1 with a queued op",
                 name, cycles, busy, cyc_q.size());
      end else begin
        c = cyc_q.pop_front();
        if ({ff_en, e_clr, e_indata} !== {c.ff_en, c.e_clr, c.e_indata}) begin
          bad++;
          $display("FAIL %s exec%0d e_ctrl: got %b%b%b want %b%b%b", name, cycles,
                   ff_en, e_clr, e_indata, c.ff_en, c.e_clr, c.e_indata);
        end
        total++;
        if (ac_out !== exp_ac) begin
          bad++;
          $display("FAIL %s exec%0d ac: got %h want %h", name, cycles, ac_out, exp_ac);
        end
        exp_ac = c.ac_after;
      end
      if (noisy) begin
        start = 1'b1; ac_load = 1'b1;
        ac_in = 16'($urandom); ir = 12'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0; ac_load = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: done=%b after %0d cycles, want done=1", name, done, cycles);
      cyc_q.delete(); res_q.delete();
      return;
    end
    r = res_q.pop_front();
    total++;
    if (cycles !== int'(r.n)) begin
      bad++;
      $display("FAIL %s exec_count: got %0d want %0d", name, cycles, r.n);
    end
    total++;
    if ({ac_out, skip, halt, e_ff} !== {r.ac, r.skip, r.halt, r.e}) begin
      bad++;
      $display("FAIL %s result ac/skip/halt/e: got %h/%b/%b/%b want %h/%b/%b/%b", name,
               ac_out, skip, halt, e_ff, r.ac, r.skip, r.halt, r.e);
    end
    total++;
    if ({busy, ff_en, e_clr, e_indata} !== 4'b1000) begin
      bad++;
      $display("FAIL %s done_cycle busy/ff_en/e_clr/e_indata: got %b%b%b%b want 1000",
               name, busy, ff_en, e_clr, e_indata);
    end
    @(negedge clk);
    total++;
    if ({done, busy, skip} !== 3'b000) begin
      bad++;
      $display("FAIL %s after_done done/busy/skip: got %b%b%b want 000", name, done, busy, skip);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ac_load = 1'b0; ir = '0; ac_in = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({ac_out, busy, done, skip, halt, ff_en, e_clr, e_indata} !== '0) begin
      bad++;
      $display("FAIL reset outputs: ac=%h busy=%b done=%b skip=%b halt=%b ff_en=%b e_clr=%b e_indata=%b, want all 0",
               ac_out, busy, done, skip, halt, ff_en, e_clr, e_indata);
    end
    reset = 1'b0;
    m_ac = '0; m_halt = 1'b0;
  endtask

  task automatic test_load();
    set_state(16'h1234, 1'b0);
    total++;
    if ({ac_out, busy, done, ff_en, e_clr, e_indata} !== {16'h1234, 5'b00000}) begin
      bad++;
      $display("FAIL load: ac=%h busy=%b done=%b e_ctrl=%b%b%b, want 1234 and controls 0",
               ac_out, busy, done, ff_en, e_clr, e_indata);
    end
  endtask

  task automatic test_cil();
    set_state(16'h8001, 1'b0);
    run_instr("cil", 12'h040, 1'b0, '0, 1'b0);
  endtask

  task automatic test_chain();
    set_state(16'h00FF, 1'b1);
    run_instr("chain", 12'h5A0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_skips();
    set_state(16'h0000, 1'b1);
    run_instr("skip_sza_true", 12'h00C, 1'b0, '0, 1'b0);
    set_state(16'h0001, 1'b1);
    run_instr("skip_none", 12'h00C, 1'b0, '0, 1'b0);
    set_state(16'h8000, 1'b0);
    run_instr("skip_sze", 12'h012, 1'b0, '0, 1'b0);
    set_state(16'h0003, 1'b1);
    run_instr("skip_spa", 12'h012, 1'b0, '0, 1'b0);
  endtask

  task automatic test_load_and_start();
    run_instr("load_start", 12'h220, 1'b1, 16'h7FFF, 1'b0);
  endtask

  task automatic test_ignore_while_busy();
    set_state(16'h0F0F, 1'b0);
    run_instr("noisy", 12'h3E4, 1'b0, '0, 1'b1);
  endtask

  task automatic test_zero_ir();
    run_instr("zero_ir", 12'h000, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_instr("b2b", 12'($urandom) & 12'hFFE, 1'b1, 16'($urandom), i[0]);
    end
  endtask

  task automatic test_halt();
    set_state(16'hABCD, 1'b0);
    run_instr("halt", 12'h801, 1'b0, '0, 1'b0);
    @(negedge clk);
    start = 1'b1; ir = 12'h020;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({busy, done} !== 2'b00) begin
        bad++;
        $display("FAIL halted_start cyc%0d busy/done: got %b%b want 00", i, busy, done);
      end
      @(negedge clk);
    end
    total++;
    if ({ac_out, halt} !== {16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL halted_state ac/halt: got %h/%b want 0000/1", ac_out, halt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ac = '0; m_halt = 1'b0;
    total++;
    if (halt !== 1'b0) begin
      bad++;
      $display("FAIL halt_cleared: got %b want 0", halt);
    end
    set_state(16'h00FE, 1'b0);
    run_instr("post_halt", 12'h020, 1'b0, '0, 1'b0);
  endtask

  task automatic test_midop_reset();
    set_state(16'h5555, 1'b1);
    @(negedge clk);
    start = 1'b1; ir = 12'hFE0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midop_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({ac_out, busy, ff_en, done} !== {16'h0000, 3'b000}) begin
      bad++;
      $display("FAIL midop_reset ac/busy/ff_en/done: got %h/%b/%b/%b want 0000/0/0/0",
               ac_out, busy, ff_en, done);
    end
    @(negedge clk);
    reset = 1'b0;
    m_ac = '0; m_halt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({done, busy} !== 2'b00) begin
        bad++;
        $display("FAIL midop_after cyc%0d done/busy: got %b%b want 00", i, done, busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_cil();
    test_chain();
    test_skips();
    test_load_and_start();
    test_ignore_while_busy();
    test_zero_ir();
    test_back_to_back();
    test_halt();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
